// File: rtl/ez90_pkg.sv
// eZ90 shared definitions used by the completion-bus (CDB) arbiter.
package ez90_pkg;

  localparam int EZ90_CDB_NUM_SRC = 32'd5;
  localparam int EZ90_CDB_SRC_INT = 32'd0;
  localparam int EZ90_CDB_SRC_BR  = 32'd1;
  localparam int EZ90_CDB_SRC_MD  = 32'd2;
  localparam int EZ90_CDB_SRC_VEC = 32'd3;
  localparam int EZ90_CDB_SRC_MEM = 32'd4;

  localparam int EZ90_CDB_TAG_W  = 32'd6;
  localparam int EZ90_CDB_DATA_W = 32'd32;
  localparam int EZ90_CDB_CNT_W  = 32'd16;
  localparam int EZ90_CDB_SRC_W  = $clog2(EZ90_CDB_NUM_SRC);

  // Default-width view of one CDB entry for downstream consumers.
  typedef struct packed {
    logic [EZ90_CDB_TAG_W-1:0]  tag;
    logic [EZ90_CDB_DATA_W-1:0] data;
    logic                       exc;
    logic [EZ90_CDB_SRC_W-1:0]  src;
  } ez90_cdb_t;

  function automatic logic ez90_multi_hot(input logic [31:0] vec);
    return (vec & (vec - 32'd1)) != 32'd0;
  endfunction

endpackage

// File: rtl/ez90_rr_arbiter.sv
// Combinational rotate-priority encoder: grants the first request at or
// after ptr_i, wrapping from NUM_REQ-1 back to 0.
module ez90_rr_arbiter #(
  parameter  int NUM_REQ = 32'd5,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   gnt_idx_o,
  output logic               gnt_valid_o
);

  logic [IDX_W-1:0] idx_s;
  logic             hit_s;
  logic             found_s;

  // Walk the requests in rotated order and latch the first hit.
  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    idx_s     = '0;
    hit_s     = 1'b0;
    found_s   = 1'b0;
    for (int k = 32'sd0; k < NUM_REQ; k++) begin
      idx_s        = IDX_W'((int'(ptr_i) + k) % NUM_REQ);
      hit_s        = !found_s && req_i[idx_s];
      gnt_o[idx_s] = hit_s;
      gnt_idx_o    = hit_s ? idx_s : gnt_idx_o;
      found_s      = found_s | hit_s;
    end
  end

  assign gnt_valid_o = found_s;

endmodule

// File: rtl/ez90_cdb_arbiter.sv
// eZ90 completion-bus arbiter: grants one FU result per cycle into a
// one-entry CDB stage, round-robin with optional fixed BR priority.
module ez90_cdb_arbiter
  import ez90_pkg::*;
#(
  parameter  int NUM_SRC = EZ90_CDB_NUM_SRC,
  parameter  int TAG_W   = EZ90_CDB_TAG_W,
  parameter  int DATA_W  = EZ90_CDB_DATA_W,
  parameter  bit BR_PRIO = 1'b1,
  parameter  int CNT_W   = EZ90_CDB_CNT_W,
  localparam int SRC_W   = $clog2(NUM_SRC)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic [NUM_SRC-1:0]        src_valid,
  input  logic [NUM_SRC*TAG_W-1:0]  src_tag,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  input  logic [NUM_SRC-1:0]        src_exc,
  output logic [NUM_SRC-1:0]        src_ready,
  output logic                      cdb_valid,
  output logic [TAG_W-1:0]          cdb_tag,
  output logic [DATA_W-1:0]         cdb_data,
  output logic                      cdb_exc,
  output logic [SRC_W-1:0]          cdb_src,
  input  logic                      cdb_ready,
  output logic [CNT_W-1:0]          conflict_cnt
);

  logic [SRC_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic               cdb_valid_q, cdb_valid_d;
  logic [TAG_W-1:0]   cdb_tag_q, cdb_tag_d;
  logic [DATA_W-1:0]  cdb_data_q, cdb_data_d;
  logic               cdb_exc_q, cdb_exc_d;
  logic [SRC_W-1:0]   cdb_src_q, cdb_src_d;
  logic [CNT_W-1:0]   conflict_cnt_q, conflict_cnt_d;

  logic               can_load_s;
  logic               grant_en_s;
  logic               br_win_s;
  logic [NUM_SRC-1:0] rr_gnt_s;
  logic [SRC_W-1:0]   rr_idx_s;
  logic               rr_any_s;
  logic [NUM_SRC-1:0] grant_s;
  logic [SRC_W-1:0]   win_idx_s;
  logic               any_grant_s;
  logic               rr_grant_s;
  logic [TAG_W-1:0]   win_tag_s;
  logic [DATA_W-1:0]  win_data_s;
  logic               win_exc_s;

  ez90_rr_arbiter #(
    .NUM_REQ (NUM_SRC)
  ) u_rr (
    .req_i       (src_valid),
    .ptr_i       (rr_ptr_q),
    .gnt_o       (rr_gnt_s),
    .gnt_idx_o   (rr_idx_s),
    .gnt_valid_o (rr_any_s)
  );

  // A full stage that drains this cycle may be refilled in the same cycle.
  assign can_load_s = !cdb_valid_q || cdb_ready;
  assign grant_en_s = can_load_s && !flush && !rst;
  assign br_win_s   = BR_PRIO && src_valid[EZ90_CDB_SRC_BR];

  // Winner selection: BR override first, otherwise the rotate encoder.
  always_comb begin
    grant_s     = '0;
    win_idx_s   = '0;
    any_grant_s = 1'b0;
    rr_grant_s  = 1'b0;
    if (grant_en_s && br_win_s) begin
      grant_s[EZ90_CDB_SRC_BR] = 1'b1;
      win_idx_s                = SRC_W'(EZ90_CDB_SRC_BR);
      any_grant_s              = 1'b1;
    end else if (grant_en_s && rr_any_s) begin
      grant_s     = rr_gnt_s;
      win_idx_s   = rr_idx_s;
      any_grant_s = 1'b1;
      rr_grant_s  = 1'b1;
    end else begin
      grant_s     = '0;
      any_grant_s = 1'b0;
    end
  end

  assign src_ready = grant_s;

  // One-hot AND-OR mux of the winning source's fields.
  always_comb begin
    win_tag_s  = '0;
    win_data_s = '0;
    win_exc_s  = 1'b0;
    for (int i = 32'sd0; i < NUM_SRC; i++) begin
      win_tag_s  = win_tag_s  | ({TAG_W{grant_s[i]}}  & src_tag[i*TAG_W +: TAG_W]);
      win_data_s = win_data_s | ({DATA_W{grant_s[i]}} & src_data[i*DATA_W +: DATA_W]);
      win_exc_s  = win_exc_s  | (grant_s[i] & src_exc[i]);
    end
  end

  // Only round-robin grants advance the pointer; BR overrides leave it alone.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (rr_grant_s) begin
      rr_ptr_d = (rr_idx_s == SRC_W'(NUM_SRC - 32'sd1)) ? '0 : rr_idx_s + 1'b1;
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
  end

  // Output stage: flush clears valid, a grant loads, a drain clears valid.
  always_comb begin
    cdb_valid_d = cdb_valid_q;
    cdb_tag_d   = cdb_tag_q;
    cdb_data_d  = cdb_data_q;
    cdb_exc_d   = cdb_exc_q;
    cdb_src_d   = cdb_src_q;
    if (flush) begin
      cdb_valid_d = 1'b0;
    end else if (any_grant_s) begin
      cdb_valid_d = 1'b1;
      cdb_tag_d   = win_tag_s;
      cdb_data_d  = win_data_s;
      cdb_exc_d   = win_exc_s;
      cdb_src_d   = win_idx_s;
    end else if (cdb_ready) begin
      cdb_valid_d = 1'b0;
    end else begin
      cdb_valid_d = cdb_valid_q;
    end
  end

  // Saturating count of granted cycles that had competing requesters.
  always_comb begin
    if (any_grant_s && ez90_multi_hot(32'(src_valid)) &&
        (conflict_cnt_q != {CNT_W{1'b1}})) begin
      conflict_cnt_d = conflict_cnt_q + 1'b1;
    end else begin
      conflict_cnt_d = conflict_cnt_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q       <= '0;
      cdb_valid_q    <= 1'b0;
      cdb_tag_q      <= '0;
      cdb_data_q     <= '0;
      cdb_exc_q      <= 1'b0;
      cdb_src_q      <= '0;
      conflict_cnt_q <= '0;
    end else begin
      rr_ptr_q       <= rr_ptr_d;
      cdb_valid_q    <= cdb_valid_d;
      cdb_tag_q      <= cdb_tag_d;
      cdb_data_q     <= cdb_data_d;
      cdb_exc_q      <= cdb_exc_d;
      cdb_src_q      <= cdb_src_d;
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  assign cdb_valid    = cdb_valid_q;
  assign cdb_tag      = cdb_tag_q;
  assign cdb_data     = cdb_data_q;
  assign cdb_exc      = cdb_exc_q;
  assign cdb_src      = cdb_src_q;
  assign conflict_cnt = conflict_cnt_q;

endmodule

// File: tb/tb_ez90_cdb_arbiter.sv
// Scoreboard bench: a pure round-robin instance and a BR-priority instance
// with a narrow counter, each checked against a cycle-level reference model.
module tb_ez90_cdb_arbiter;
  localparam int NS = 5;
  localparam int TW = 6;
  localparam int DW = 32;
  localparam int SW = 3;

  typedef struct {
    logic [TW-1:0] tag;
    logic [DW-1:0] data;
    logic          exc;
    logic [SW-1:0] src;
  } ent_t;

  logic clk = 1'b0;
  logic rst;
  logic [NS-1:0]    sv [2];
  logic [NS*TW-1:0] st [2];
  logic [NS*DW-1:0] sd [2];
  logic [NS-1:0]    se [2];
  logic             fl [2];
  logic             rdy [2];
  logic [NS-1:0]    sr [2];
  logic             cv [2];
  logic [TW-1:0]    ct [2];
  logic [DW-1:0]    cd [2];
  logic             ce [2];
  logic [SW-1:0]    cs [2];
  logic [15:0]      cnt_a;
  logic [3:0]       cnt_b;

  int   n_tests = 0;
  int   n_fail  = 0;
  ent_t q0[$];
  ent_t q1[$];
  int   m_ptr [2];
  int   m_cnt [2];
  bit   m_cv  [2];
  int   m_win [2];
  int   cnt_max [2] = '{65535, 15};
  bit   prio    [2] = '{1'b0, 1'b1};
  int   waitg [NS];

  always #5 clk = ~clk;

  ez90_cdb_arbiter #(.NUM_SRC(NS), .TAG_W(TW), .DATA_W(DW), .BR_PRIO(1'b0), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .flush(fl[0]), .src_valid(sv[0]), .src_tag(st[0]), .src_data(sd[0]),
    .src_exc(se[0]), .src_ready(sr[0]), .cdb_valid(cv[0]), .cdb_tag(ct[0]), .cdb_data(cd[0]),
    .cdb_exc(ce[0]), .cdb_src(cs[0]), .cdb_ready(rdy[0]), .conflict_cnt(cnt_a));

  ez90_cdb_arbiter #(.NUM_SRC(NS), .TAG_W(TW), .DATA_W(DW), .BR_PRIO(1'b1), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .flush(fl[1]), .src_valid(sv[1]), .src_tag(st[1]), .src_data(sd[1]),
    .src_exc(se[1]), .src_ready(sr[1]), .cdb_valid(cv[1]), .cdb_tag(ct[1]), .cdb_data(cd[1]),
    .cdb_exc(ce[1]), .cdb_src(cs[1]), .cdb_ready(rdy[1]), .conflict_cnt(cnt_b));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int qsize(input int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction

  function automatic ent_t qfront(input int d);
    return (d == 0) ? q0[0] : q1[0];
  endfunction

  task automatic qpop(input int d);
    if (d == 0) void'(q0.pop_front());
    else void'(q1.pop_front());
  endtask

  task automatic qpush(input int d, input ent_t e);
    if (d == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  task automatic renew(input int d, input int i);
    st[d][i*TW +: TW] = TW'($urandom);
    sd[d][i*DW +: DW] = $urandom;
    se[d][i]          = 1'($urandom_range(0, 1));
  endtask

  // Reference model: evaluated once per cycle once inputs are stable.
  task automatic model_step(input int d);
    int            win;
    logic [NS-1:0] v;
    logic [NS-1:0] exp_r;
    ent_t          e;
    v = sv[d];
    if (rst) begin
      chk("rst_src_ready", 64'(sr[d]), 64'd0);
      chk("rst_cdb_valid", 64'(cv[d]), 64'd0);
      chk("rst_conflict_cnt", (d == 0) ? 64'(cnt_a) : 64'(cnt_b), 64'd0);
      m_ptr[d] = 0; m_cnt[d] = 0; m_cv[d] = 1'b0; m_win[d] = -1;
      if (d == 0) begin q0.delete(); for (int i = 0; i < NS; i++) waitg[i] = 0; end
      else q1.delete();
      return;
    end
    chk("cdb_valid", 64'(cv[d]), 64'(m_cv[d]));
    chk("conflict_cnt", (d == 0) ? 64'(cnt_a) : 64'(cnt_b), 64'(m_cnt[d]));
    win = -1;
    if ((!m_cv[d] || rdy[d]) && !fl[d]) begin
      if (prio[d] && v[1]) win = 1;
      else
        for (int k = 0; k < NS; k++)
          if (win < 0 && v[(m_ptr[d] + k) % NS]) win = (m_ptr[d] + k) % NS;
    end
    exp_r = '0;
    if (win >= 0) exp_r[win] = 1'b1;
    chk("src_ready", 64'(sr[d]), 64'(exp_r));
    chk("ready_onehot", 64'($onehot0(sr[d])), 64'd1);
    if (win >= 0) begin
      e.tag  = st[d][win*TW +: TW];
      e.data = sd[d][win*DW +: DW];
      e.exc  = se[d][win];
      e.src  = SW'(win);
      qpush(d, e);
      if (!(prio[d] && win == 1)) m_ptr[d] = (win + 1) % NS;
      if ($countones(v) > 1 && m_cnt[d] < cnt_max[d]) m_cnt[d]++;
      if (d == 0)
        for (int i = 0; i < NS; i++) begin
          if (i == win || !v[i]) waitg[i] = 0;
          else begin
            waitg[i]++;
            chk("starvation_bound", 64'(waitg[i] <= NS - 1), 64'd1);
          end
        end
    end
    if (fl[d]) m_cv[d] = 1'b0;
    else if (win >= 0) m_cv[d] = 1'b1;
    else if (rdy[d]) m_cv[d] = 1'b0;
    m_win[d] = win;
  endtask

  // Monitor: the staged entry must match the oldest accepted result.
  task automatic mon_step(input int d);
    ent_t e;
    if (cv[d] === 1'b1) begin
      if (qsize(d) == 0) begin
        n_tests++; n_fail++;
        $display("FAIL cdb_unexpected[%0d]: got valid entry src=%0d, expected none", d, cs[d]);
      end else begin
        e = qfront(d);
        if (!fl[d]) begin
          chk("cdb_tag", 64'(ct[d]), 64'(e.tag));
          chk("cdb_data", 64'(cd[d]), 64'(e.data));
          chk("cdb_exc", 64'(ce[d]), 64'(e.exc));
          chk("cdb_src", 64'(cs[d]), 64'(e.src));
        end
        if (fl[d] || rdy[d]) qpop(d);
      end
    end
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (!rst) for (int d = 0; d < 2; d++) mon_step(d);
    end
  end

  initial begin : model
    forever begin
      @(negedge clk);
      #1;
      for (int d = 0; d < 2; d++) model_step(d);
    end
  end

  // Sources renew their result once accepted; unaccepted ones hold unless flushed.
  task automatic next_inputs(input int d, input bit rnd, input logic [NS-1:0] vm,
                             input logic f, input logic r);
    for (int i = 0; i < NS; i++) begin
      if (rnd) begin
        if (m_win[d] == i || !sv[d][i] || fl[d]) begin
          sv[d][i] = ($urandom_range(0, 99) < 60);
          renew(d, i);
        end
      end else begin
        if (m_win[d] == i) renew(d, i);
        sv[d][i] = vm[i];
      end
    end
    fl[d]  = f;
    rdy[d] = r;
  endtask

  task automatic dir(input logic [NS-1:0] vm0, input logic f0, input logic r0,
                     input logic [NS-1:0] vm1, input logic f1, input logic r1);
    next_inputs(0, 1'b0, vm0, f0, r0);
    next_inputs(1, 1'b0, vm1, f1, r1);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin : stim
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      sv[d] = '1; fl[d] = 1'b0; rdy[d] = 1'b1; m_win[d] = -1;
      for (int i = 0; i < NS; i++) renew(d, i);
    end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // All sources valid straight out of reset.
    for (int k = 0; k < 5; k++) begin
      tick();
      if (k == 0) begin
        chk("t1_cdb_valid", 64'(cv[0]), 64'd1);
        chk("t1_cdb_src_int", 64'(cs[0]), 64'd0);
        chk("t1_br_prio_src", 64'(cs[1]), 64'd1);
      end
      dir('1, 1'b0, 1'b1, '1, 1'b0, 1'b1);
    end
    tick();
    chk("t2_conflict_cnt_6", 64'(cnt_a), 64'd6);
    dir('0, 1'b0, 1'b1, '1, 1'b0, 1'b1);
    repeat (12) begin
      tick();
      dir('0, 1'b0, 1'b1, '1, 1'b0, 1'b1);
    end
    tick();
    chk("t6_conflict_saturated", 64'(cnt_b), 64'hF);

    // Backpressure: tag 0x15 staged and held for three cycles, then refill.
    dir(5'b00001, 1'b0, 1'b1, '0, 1'b0, 1'b1);
    st[0][TW-1:0] = 6'h15;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t3_hold_tag", 64'(ct[0]), 64'h15);
      chk("t3_hold_valid", 64'(cv[0]), 64'd1);
      dir(5'b01000, 1'b0, 1'b0, '0, 1'b0, 1'b1);
    end
    tick();
    chk("t3_hold_tag_last", 64'(ct[0]), 64'h15);
    dir(5'b01000, 1'b0, 1'b1, '0, 1'b0, 1'b1);
    tick();
    chk("t3_refill_src", 64'(cs[0]), 64'd3);

    // Flush on instance A; BR priority vs pointer on instance B.
    dir(5'b10000, 1'b1, 1'b0, 5'b00100, 1'b0, 1'b1);
    tick();
    chk("t5_flush_clears_valid", 64'(cv[0]), 64'd0);
    chk("t4_rr_src2", 64'(cs[1]), 64'd2);
    dir(5'b10001, 1'b0, 1'b1, 5'b01010, 1'b0, 1'b1);
    tick();
    chk("t5_ptr_kept_src4", 64'(cs[0]), 64'd4);
    chk("t4_br_wins", 64'(cs[1]), 64'd1);
    dir('0, 1'b0, 1'b1, 5'b01100, 1'b0, 1'b1);
    tick();
    chk("t4_ptr_kept_src3", 64'(cs[1]), 64'd3);

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      tick();
      for (int d = 0; d < 2; d++)
        next_inputs(d, 1'b1, '0, ($urandom_range(0, 99) < 4), ($urandom_range(0, 99) < 70));
    end

    repeat (6) begin
      tick();
      dir('0, 1'b0, 1'b1, '0, 1'b0, 1'b1);
    end
    tick();
    chk("drain_queue_a", 64'(q0.size()), 64'd0);
    chk("drain_queue_b", 64'(q1.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
